// File: rtl/imem_loader.sv
// Instruction-memory loader: packs an MSB-first byte stream into 32-bit words and writes them.
// Optional running XOR checksum of written words when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 3,
  parameter int WORD_COUNT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_cnt
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(WORD_COUNT - 1);

  state_t      r_state;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic        w_accept;

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_idx <= 2'd0;
      r_word     <= 24'd0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum   <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_byte_idx <= 2'd0;
            mem_addr   <= '0;
            word_cnt   <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= 32'd0;
`endif
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[23:16] <= in_data;
              2'd1: r_word[15:8]  <= in_data;
              2'd2: r_word[7:0]   <= in_data;
              default: begin
                // Last byte goes straight to mem_din so the word appears together with mem_we.
                mem_din  <= {r_word, in_data};
                mem_we   <= 1'b1;
                in_ready <= 1'b0;
                r_state  <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          mem_we   <= 1'b0;
          word_cnt <= word_cnt + (ADDR_WIDTH+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum <= checksum ^ mem_din;
`endif
          if (mem_addr == LP_LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state  <= S_LOAD;
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            in_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default parameters, plus a
// two-word checksum instance when IMEM_LOADER_CHECKSUM_EN is defined).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [31:0] mem_din;
  logic        busy;
  logic        done;
  logic [3:0]  word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
  logic        start2 = 1'b0;
  logic        in_valid2 = 1'b0;
  logic [7:0]  in_data2 = 8'd0;
  logic        in_ready2, mem_we2, busy2, done2;
  logic [0:0]  mem_addr2;
  logic [31:0] mem_din2, checksum2;
  logic [1:0]  word_cnt2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  q_addr[$];
  logic [31:0] q_data[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(3), .WORD_COUNT(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .word_cnt(word_cnt)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  imem_loader #(.ADDR_WIDTH(1), .WORD_COUNT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2),
    .busy(busy2), .done(done2), .word_cnt(word_cnt2), .checksum(checksum2)
  );
`endif

  // Write log captured mid-cycle while mem_we is high
  always @(negedge clk) begin
    if (mem_we) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_din);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check_eq("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic check_session(input string tag, input logic [7:0] base);
    logic [31:0] w;
    check_eq({tag, "_nwrites"}, 32'(q_addr.size()), 32'd8);
    if (q_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        w = {base + 8'(4*i), base + 8'(4*i+1), base + 8'(4*i+2), base + 8'(4*i+3)};
        check_eq($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(i));
        check_eq($sformatf("%s_word%0d", tag, i), q_data[i], w);
      end
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_word_cnt"}, 32'(word_cnt), 32'd8);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd7);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_din"}, mem_din, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
  endtask

  initial begin
    logic [31:0] x;

    // Reset
    #3 rst = 1'b1;
    #1 check_all_zero("reset");
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Full session 0x00..0x1F
    pulse_start();
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_in_ready", 32'(in_ready), 32'd1);
    clear_log();
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    wait_done();
    check_session("s1", 8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 32'd0;
    for (int i = 0; i < 8; i++) x ^= {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    check_eq("s1_checksum", checksum, x);
`endif

    // Restart from DONE
    pulse_start();
    check_eq("restart_busy", 32'(busy), 32'd1);
    check_eq("restart_word_cnt", 32'(word_cnt), 32'd0);
    check_eq("restart_in_ready", 32'(in_ready), 32'd1);
    check_eq("restart_done", 32'(done), 32'd0);
    check_eq("restart_mem_addr", 32'(mem_addr), 32'd0);

    // Stalled word DEADBEEF
    clear_log();
    send_byte(8'hDE);
    send_byte(8'hAD);
    idle_cycles(5);
    send_byte(8'hBE);
    send_byte(8'hEF);
    idle_cycles(3);
    check_eq("stall_nwrites", 32'(q_addr.size()), 32'd1);
    if (q_addr.size() == 1) begin
      check_eq("stall_addr", 32'(q_addr[0]), 32'd0);
      check_eq("stall_word", q_data[0], 32'hDEADBEEF);
    end
    check_eq("stall_din_hold", mem_din, 32'hDEADBEEF);
    check_eq("stall_mem_we", 32'(mem_we), 32'd0);
    check_eq("stall_word_cnt", 32'(word_cnt), 32'd1);
    check_eq("stall_mem_addr", 32'(mem_addr), 32'd1);

    // Reset mid-session after 6 bytes
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    pulse_start();
    clear_log();
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    check_eq("pre_rst_nwrites", 32'(q_addr.size()), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    #2 rst = 1'b0;
    idle_cycles(3);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("post_rst_mem_we", 32'(mem_we), 32'd0);
    clear_log();
    pulse_start();
    for (int i = 0; i < 32; i++) send_byte(8'h40 + 8'(i));
    wait_done();
    check_session("s2", 8'h40);

    // start ignored during LOAD and WRITE
    pulse_start();
    clear_log();
    send_byte(8'h80);
    send_byte(8'h81);
    pulse_start();
    check_eq("load_start_busy", 32'(busy), 32'd1);
    check_eq("load_start_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'h82);
    send_byte(8'h83);
    check_eq("in_write_mem_we", 32'(mem_we), 32'd1);
    check_eq("in_write_in_ready", 32'(in_ready), 32'd0);
    pulse_start();
    check_eq("write_start_mem_addr", 32'(mem_addr), 32'd1);
    check_eq("write_start_word_cnt", 32'(word_cnt), 32'd1);
    check_eq("write_start_in_ready", 32'(in_ready), 32'd1);
    for (int i = 4; i < 32; i++) send_byte(8'h80 + 8'(i));
    wait_done();
    check_session("s3", 8'h80);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Two-word checksum instance
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid2 = 1'b1;
      in_data2  = (i < 4) ? 8'h11 : 8'h22;
      for (int j = 0; j < 50; j++) begin
        @(negedge clk);
        if (in_ready2) break;
      end
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
    end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done2) break;
    end
    check_eq("cs_done", 32'(done2), 32'd1);
    check_eq("cs_word_cnt", 32'(word_cnt2), 32'd2);
    check_eq("cs_checksum", checksum2, 32'h33333333);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
